// File: rtl/siso_deserializer.sv
// siso_deserializer: frames a qualified MSB-first serial bit stream into
// N-bit words and presents them on a valid/ready parallel interface.
// Reports frame errors (sync arriving mid-word) and overflow (dropped word).
module siso_deserializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         sync,
  output logic [N-1:0] par_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err,
  output logic         overflow,
  input  logic         clr_overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (N < 2) begin : g_bad_width
      $error("siso_deserializer: N must be at least 2");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    par_q, par_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovf_q, ovf_d;
  logic            complete;
  logic            drop;
  logic [N-1:0]    word;

  assign word = {shreg_q[N-2:0], serial_in};

  // Framing FSM, bit counter, output stage and overflow flag next-state logic.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovf_d    = ovf_q;
    complete = 1'b0;
    drop     = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            shreg_d = word;
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // Sync always restarts the word; only a pending partial is an error.
            ferr_d  = (cnt_q != '0);
            shreg_d = word;
            cnt_d   = CW'(1);
          end else if (cnt_q == LAST) begin
            shreg_d  = word;
            cnt_d    = '0;
            complete = 1'b1;
          end else begin
            shreg_d = word;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      if (!valid_q || out_ready) begin
        par_d   = word;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign par_out   = par_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_siso_deserializer.sv
// Self-checking bench for siso_deserializer: queue-based word-framing model,
// per-cycle compare process, directed scenarios and a randomized run.
module tb_siso_deserializer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         sync = 1'b0;
  logic [N-1:0] par_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_err;
  logic         overflow;
  logic         clr_overflow = 1'b0;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  siso_deserializer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .sync         (sync),
    .par_out      (par_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: bits of the current word kept in a queue.
  logic [N-1:0] m_par   = '0;
  logic         m_valid = 1'b0;
  logic         m_ferr  = 1'b0;
  logic         m_ovf   = 1'b0;
  bit           m_framing = 1'b0;
  bit           m_cur[$];

  always @(posedge clk or negedge rst) begin
    logic [N-1:0] w;
    bit done;
    bit take;
    if (!rst) begin
      m_par = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      m_framing = 1'b0; m_cur.delete();
    end else begin
      take   = m_valid && out_ready;
      m_ferr = 1'b0;
      done   = 1'b0;
      w      = '0;
      if (bit_valid) begin
        if (sync) begin
          if (m_framing && m_cur.size() > 0) m_ferr = 1'b1;
          m_cur.delete();
          m_cur.push_back(serial_in);
          m_framing = 1'b1;
        end else if (m_framing) begin
          m_cur.push_back(serial_in);
          if (m_cur.size() == N) begin
            foreach (m_cur[i]) w = (w << 1) | N'(m_cur[i]);
            m_cur.delete();
            done = 1'b1;
          end
        end
      end
      if (done && m_valid && !out_ready) begin
        m_ovf = 1'b1;
      end else begin
        if (clr_overflow) m_ovf = 1'b0;
        if (done) begin
          m_par = w; m_valid = 1'b1;
        end else if (take) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model.out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) check("model.par_out", 32'(par_out), 32'(m_par));
      check("model.frame_err", 32'(frame_err), 32'(m_ferr));
      check("model.overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic drive(input logic v, input logic s, input logic d, input logic r, input logic c);
    @(negedge clk);
    bit_valid = v; sync = s; serial_in = d; out_ready = r; clr_overflow = c;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic s_first, input logic r);
    for (int i = N - 1; i >= 0; i--) drive(1'b1, (i == N - 1) ? s_first : 1'b0, w[i], r, 1'b0);
  endtask

  initial begin
    chk_en = 1'b1;
    @(negedge clk);
    check("reset.par_out", 32'(par_out), 32'h0);
    check("reset.out_valid", 32'(out_valid), 32'h0);
    check("reset.overflow", 32'(overflow), 32'h0);
    rst = 1'b1;

    // Word 1011 with ready held high.
    drive(1, 1, 1, 1, 0); drive(1, 0, 0, 1, 0); drive(1, 0, 1, 1, 0); drive(1, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("t1.par_out", 32'(par_out), 32'hB);
    check("t1.out_valid", 32'(out_valid), 32'h1);
    drive(0, 0, 0, 1, 0);
    check("t1.valid_drop", 32'(out_valid), 32'h0);

    // Bits 1,1,0,0 with gaps.
    drive(1, 1, 1, 1, 0); drive(0, 0, 0, 1, 0); drive(1, 0, 1, 1, 0); drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 0); drive(1, 0, 0, 1, 0); drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("t2.par_out", 32'(par_out), 32'hC);

    // Back-to-back A then 5 without a second sync.
    send_word(4'hA, 1, 1);
    send_word(4'h5, 0, 1);
    drive(0, 0, 0, 1, 0);
    check("t3.par_out", 32'(par_out), 32'h5);
    check("t3.overflow", 32'(overflow), 32'h0);

    // Overflow: 3 pending, C dropped.
    drive(0, 0, 0, 1, 0);
    send_word(4'h3, 1, 0);
    send_word(4'hC, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("t4.par_out", 32'(par_out), 32'h3);
    check("t4.out_valid", 32'(out_valid), 32'h1);
    check("t4.overflow", 32'(overflow), 32'h1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    check("t4.accepted", 32'(out_valid), 32'h0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("t4.clr_overflow", 32'(overflow), 32'h0);

    // Frame error: sync after two bits, then 0110.
    drive(1, 1, 1, 1, 0); drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 1, 0); drive(1, 0, 1, 1, 0);
    check("t5.frame_err", 32'(frame_err), 32'h1);
    drive(1, 0, 1, 1, 0);
    check("t5.frame_err_pulse", 32'(frame_err), 32'h0);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    check("t5.par_out", 32'(par_out), 32'h6);

    // Asynchronous reset mid-word with a word pending.
    send_word(4'hF, 1, 0);
    drive(1, 1, 1, 0, 0); drive(1, 0, 0, 0, 0); drive(1, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    bit_valid = 1'b0; sync = 1'b0;
    rst = 1'b0;
    #1;
    check("t6.rst_par_out", 32'(par_out), 32'h0);
    check("t6.rst_out_valid", 32'(out_valid), 32'h0);
    check("t6.rst_overflow", 32'(overflow), 32'h0);
    check("t6.rst_frame_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 1, 1, 0); drive(1, 0, 1, 1, 0); drive(1, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("t6.idle_ignored", 32'(out_valid), 32'h0);
    send_word(4'h9, 1, 1);
    drive(0, 0, 0, 0, 0);
    check("t6.par_out", 32'(par_out), 32'h9);
    check("t6.out_valid", 32'(out_valid), 32'h1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) == 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) < 6),
            logic'($urandom_range(0, 19) == 0));
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/siso_deserializer.md
Name: siso_deserializer

Overview:
- Receive end of the serial link driven by the team's N-bit SISO shift register. Samples a qualified serial bit stream MSB-first (first bit out of the SISO is its MSB), frames it into N-bit words, and presents each word on a valid/ready parallel interface.
- Flags frame errors (sync mid-word) and overflow (word completes while the previous one is still unaccepted).

Parameters:
- N, 4, word width in bits; legal range N >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- serial_in  input  1  serial data bit, sampled only when bit_valid = 1.
- bit_valid  input  1  qualifies serial_in for this cycle.
- sync  input  1  marks the current valid bit as bit 0 (MSB) of a new word; ignored when bit_valid = 0.
- par_out  output  N  received word, MSB = first bit received.
- out_valid  output  1  par_out holds an unaccepted word.
- out_ready  input  1  consumer accepts par_out when out_valid & out_ready.
- frame_err  output  1  one-cycle pulse: sync arrived with a partial word pending.
- overflow  output  1  sticky: a completed word was dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; shift register, bit counter and par_out = 0; out_valid, frame_err and overflow = 0. Deassertion is sampled at the next rising edge.
- Bit counter: width $clog2(N); counts valid bits received in the current word, 0..N-1.
- Shift: on each accepted bit, shreg <= {shreg[N-2:0], serial_in}. The word is complete on the Nth bit.
- FSM IDLE:
  - bit_valid & sync: shift in the bit, cnt = 1, go to RECV.
  - bit_valid & !sync: bit discarded, stay in IDLE.
- FSM RECV:
  - bit_valid & !sync, cnt < N-1: shift in the bit, cnt++.
  - bit_valid & !sync, cnt = N-1: word complete. Load {shreg[N-2:0], serial_in} into the output stage (rules below), cnt = 0, stay in RECV. The next word needs no sync; sync is optional on word boundaries.
  - bit_valid & sync, cnt != 0: discard the partial word, pulse frame_err for 1 cycle, shift in this bit as the new MSB, cnt = 1.
  - bit_valid & sync, cnt = 0: normal word start, no error.
- N = 1-bit edge case does not exist: N >= 2 is enforced by an elaboration-time check.
- Output stage (evaluated at the completion edge):
  - out_valid = 0, or out_valid & out_ready in the same cycle: par_out <= new word, out_valid <= 1.
  - out_valid = 1 & out_ready = 0: new word dropped, par_out unchanged, overflow <= 1.
  - No completion and out_valid & out_ready: out_valid <= 0. par_out holds its stale value.
- Latency: par_out and out_valid are valid in the cycle after the edge that samples the Nth bit. Maximum throughput is one word per N valid bits.
- Stability: while out_valid = 1 and not accepted, par_out does not change.
- overflow: stays set until clr_overflow = 1. If clr_overflow and a new drop occur in the same cycle, the set wins.
- bit_valid = 0 cycles are gaps: no state change. Gaps may occur at any bit position.
- Reset mid-word or with out_valid = 1: all state is lost immediately and outputs return to reset values.

Test Plan:
- Reset, then sync+bit_valid with bits 1,0,1,1 on consecutive cycles, out_ready = 1 -> par_out = 4'b1011 and out_valid = 1 the cycle after the 4th bit. out_valid drops the cycle after acceptance.
- Bits 1,1,0,0 with bit_valid gaps (1-0-1-0-0-1-1 pattern) -> par_out = 4'b1100. No frame_err.
- Back-to-back words 4'hA then 4'h5 (no second sync), out_ready held at 1 -> two handshakes with par_out A then 5. overflow = 0.
- out_ready = 0 while words 4'h3 then 4'hC complete -> par_out stays 4'h3 and overflow = 1. Raise out_ready -> 4'h3 accepted. Assert clr_overflow -> overflow = 0.
- Sync after 2 bits (1,0), then sync-started bits 0,1,1,0 -> single frame_err pulse and par_out = 4'h6 (partial discarded).
- Assert rst = 0 asynchronously mid-clock after 3 bits of a word -> all outputs 0 immediately. After release, a fresh sync word 4'h9 is received correctly. Bits without sync in IDLE are ignored.
